// File: rtl/frame_capture_ctrl_pkg.sv
// Shared definitions for the video capture path: FSM state encoding and default widths.
package video_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_COUNT_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } captureState_t;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Pixel stream in and FIFO write port out; master is the capture sequencer side.
interface frame_capture_ctrl_if import video_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  sof;
  logic                  pixValid;
  logic [DATA_WIDTH-1:0] pixData;
  logic                  fifoFull;
  logic                  fifoWrEn;
  logic [DATA_WIDTH-1:0] fifoData;

  modport master (
    input  sof, pixValid, pixData, fifoFull,
    output fifoWrEn, fifoData
  );

  modport slave (
    output sof, pixValid, pixData, fifoFull,
    input  fifoWrEn, fifoData
  );

endinterface

// File: rtl/frame_capture_ctrl_pixel_counter.sv
// Pixel counter with latched frame size; oTerminal flags that the next counted pixel completes the frame.
module pixel_counter import video_pkg::*; #(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   iClk,
  input  logic                   iResetN,
  input  logic                   iLoad,
  input  logic [COUNT_WIDTH-1:0] iSize,
  input  logic                   iInc,
  output logic [COUNT_WIDTH-1:0] oCount,
  output logic                   oTerminal
);

  logic [COUNT_WIDTH-1:0] sizeReg;

  // Load latches a new size and restarts the count; saturate rather than wrap.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      oCount  <= '0;
      sizeReg <= '0;
    end else if (iLoad) begin
      oCount  <= '0;
      sizeReg <= iSize;
    end else if (iInc && (oCount != '1)) begin
      oCount <= oCount + 1'b1;
    end
  end

  assign oTerminal = (({1'b0, oCount} + (COUNT_WIDTH + 1)'(1)) == {1'b0, sizeReg});

endmodule

// File: rtl/frame_capture_ctrl.sv
// Write-side sequencer for the video-to-CPU FIFO: arms on iStart, captures one frame from the next SOF.
module frame_capture_ctrl import video_pkg::*; #(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   iClk,
  input  logic                   iResetN,
  input  logic                   iStart,
  input  logic                   iAbort,
  input  logic [COUNT_WIDTH-1:0] iFrameSize,
  frame_capture_ctrl_if.master   bus,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oOverflow,
  output logic                   oShortFrame,
  output logic [COUNT_WIDTH-1:0] oPixCount
);

  captureState_t         state;
  logic                  acceptStart;
  logic                  countPixel;
  logic                  shortEvt;
  logic                  terminal;
  logic [DATA_WIDTH-1:0] pixData;
  logic                  fifoWrEn;
  logic [DATA_WIDTH-1:0] fifoData;

  assign pixData      = bus.pixData;
  assign bus.fifoWrEn = fifoWrEn;
  assign bus.fifoData = fifoData;

  // A SOF in CAPTURE ends the frame early unless that same pixel is the last one anyway.
  always_comb begin
    acceptStart = (state == IDLE) && iStart && (iFrameSize != '0);
    countPixel  = 1'b0;
    shortEvt    = 1'b0;
    case (state)
      WAIT_SOF: countPixel = !iAbort && bus.sof && bus.pixValid;
      CAPTURE: begin
        shortEvt   = !iAbort && bus.sof && !(bus.pixValid && terminal);
        countPixel = !iAbort && bus.pixValid && !shortEvt;
      end
      default: ;
    endcase
  end

  pixel_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) uCounter (
    .iClk      (iClk),
    .iResetN   (iResetN),
    .iLoad     (acceptStart),
    .iSize     (iFrameSize),
    .iInc      (countPixel),
    .oCount    (oPixCount),
    .oTerminal (terminal)
  );

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state       <= IDLE;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oOverflow   <= 1'b0;
      oShortFrame <= 1'b0;
      fifoWrEn    <= 1'b0;
      fifoData    <= '0;
    end else begin
      fifoWrEn <= 1'b0;
      oDone    <= 1'b0;

      // Dropped pixels still count so the frame stays aligned with the sensor.
      if (countPixel) begin
        if (bus.fifoFull) begin
          oOverflow <= 1'b1;
        end else begin
          fifoWrEn <= 1'b1;
          fifoData <= pixData;
        end
      end

      case (state)
        IDLE: begin
          if (acceptStart) begin
            state       <= WAIT_SOF;
            oBusy       <= 1'b1;
            oOverflow   <= 1'b0;
            oShortFrame <= 1'b0;
          end
        end
        WAIT_SOF: begin
          if (iAbort) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else if (bus.sof) begin
            if (countPixel && terminal) begin
              state <= IDLE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (iAbort) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else if (shortEvt) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oDone       <= 1'b1;
            oShortFrame <= 1'b1;
          end else if (countPixel && terminal) begin
            state <= IDLE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
